rv32_mtimer: RTL

RV32_MTIMER -- requirements
Module: rv32_mtimer

---
 rtl/rv32_mtimer_pkg.sv | 36 +++
 rtl/rv32_mtimer_prescaler.sv | 36 +++
 rtl/rv32_mtimer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rv32_mtimer_pkg.sv
// Shared definitions for the RV32 machine timer: the register index map,
// the compare reset value and a byte-enable merge helper.
package rv32_mtimer_pkg;

    // Register indices as decoded from address bits [4:2].
    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] PRESCALE    = 3'd4;

    // Highest index that maps to a real register; anything above faults.
    localparam logic [2:0] LAST_MAPPED_INDEX = PRESCALE;

    // MTIMECMP powers up at its maximum so the interrupt stays quiet
    // until software programs a real deadline.
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Merge a bus write into a 32-bit word: enabled bytes take the new
    // data, disabled bytes keep the current contents.
    function automatic logic [31:0] apply_byte_mask(
        input logic [31:0] currentWord,
        input logic [31:0] writeWord,
        input logic [3:0]  byteEnable
    );
        logic [31:0] merged;
        merged = currentWord;
        for (int b = 0; b < 4; b++) begin
            if (byteEnable[b]) begin
                merged[8*b +: 8] = writeWord[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rv32_mtimer_prescaler.sv
// Prescaler for the machine timer: divides the clock by (prescale + 1)
// and emits a single-cycle tick at the end of each period.
module rv32_mtimer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] prescale,
    input  logic        clear,
    output logic        tick_out
);

    logic [15:0] pcnt_q;
    logic [15:0] pcnt_d;

    // The period ends when the counter has reached the programmed
    // prescale value; a prescale of zero therefore ticks every cycle.
    assign tick_out = (pcnt_q == prescale);

    // Wrap the counter at the end of a period, and restart it whenever
    // software reprograms the prescale value so the new period is whole.
    always_comb begin
        pcnt_d = pcnt_q + 16'd1;
        if (clear || tick_out) begin
            pcnt_d = 16'd0;
        end
    end

    // Counter register; reset throws away any partial period.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= 16'd0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/rv32_mtimer.sv
// RV32 machine timer: 64-bit MTIME counter advanced by a prescaled tick,
// 64-bit MTIMECMP deadline, bus-accessible register file with byte
// enables, and a registered machine timer interrupt.
module rv32_mtimer
    import rv32_mtimer_pkg::*;
#(
    parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [31:0] address_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        fault_out,
    output logic        interrupt_out
);

    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic [15:0] prescale_q;
    logic [15:0] prescale_d;
    logic        irq_q;

    logic [2:0]  regIndex;
    logic        indexMapped;
    logic        writeEn;
    logic        readEn;
    logic        prescaleWrite;
    logic        tick;
    logic        unusedAddressBits;

    // Only the word index participates in decoding; the remaining address
    // bits are deliberately ignored.
    assign regIndex          = address_in[4:2];
    assign unusedAddressBits = ^{address_in[31:5], address_in[1:0]};

    assign indexMapped   = (regIndex <= LAST_MAPPED_INDEX);
    assign writeEn       = sel_in && write_in && indexMapped;
    assign readEn        = sel_in && read_in && indexMapped;
    assign fault_out     = sel_in && (read_in || write_in) && !indexMapped;
    assign prescaleWrite = writeEn && (regIndex == PRESCALE);

    rv32_mtimer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale_q),
        .clear    (prescaleWrite),
        .tick_out (tick)
    );

    // MTIME next state: a bus write to either half wins over the tick, so
    // software sees exactly the value it wrote; otherwise advance on tick
    // as one 64-bit quantity so the low word carries into the high word.
    always_comb begin
        mtime_d = mtime_q;
        if (writeEn && (regIndex == MTIME_LO)) begin
            mtime_d[31:0] = apply_byte_mask(mtime_q[31:0], write_value_in, write_mask_in);
        end else if (writeEn && (regIndex == MTIME_HI)) begin
            mtime_d[63:32] = apply_byte_mask(mtime_q[63:32], write_value_in, write_mask_in);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // MTIMECMP and PRESCALE next state: byte-masked bus writes only.
    // PRESCALE is 16 bits wide, so only the two low byte enables matter.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        prescale_d = prescale_q;
        if (writeEn && (regIndex == MTIMECMP_LO)) begin
            mtimecmp_d[31:0] = apply_byte_mask(mtimecmp_q[31:0], write_value_in, write_mask_in);
        end
        if (writeEn && (regIndex == MTIMECMP_HI)) begin
            mtimecmp_d[63:32] = apply_byte_mask(mtimecmp_q[63:32], write_value_in, write_mask_in);
        end
        if (prescaleWrite) begin
            if (write_mask_in[0]) begin
                prescale_d[7:0] = write_value_in[7:0];
            end
            if (write_mask_in[1]) begin
                prescale_d[15:8] = write_value_in[15:8];
            end
        end
    end

    // Combinational read port: returns the current (pre-write) value of
    // the addressed register, and zero whenever no valid read is present.
    always_comb begin
        read_value_out = 32'd0;
        if (readEn) begin
            case (regIndex)
                MTIME_LO:    read_value_out = mtime_q[31:0];
                MTIME_HI:    read_value_out = mtime_q[63:32];
                MTIMECMP_LO: read_value_out = mtimecmp_q[31:0];
                MTIMECMP_HI: read_value_out = mtimecmp_q[63:32];
                PRESCALE:    read_value_out = {16'd0, prescale_q};
                default:     read_value_out = 32'd0;
            endcase
        end
    end

    // Register file and interrupt flop; reset overrides any write or tick.
    // The interrupt compares the current register values, so it follows
    // a change of MTIME or MTIMECMP one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RESET;
            prescale_q <= RESET_PRESCALE;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            prescale_q <= prescale_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign interrupt_out = irq_q;

endmodule
